// File: rtl/iram_portb_arb_pkg.sv
// Shared constants, RMW state encoding and helpers for the IRAM port-B arbiter.
package iram_portb_arb_pkg;

  localparam int INST_W     = 32;     // instruction bus width
  localparam int IRAM_DEPTH = 65536;  // default IRAM depth in words

  typedef enum logic [1:0] {ST_IDLE, ST_RMW_RD, ST_RMW_WR} rmw_st_e;

  // Address bits needed to index 0..value, same helper the RAM model uses.
  function automatic int clogb2(input int value);
    int v;
    int r;
    v = value;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic logic [INST_W-1:0] byte_merge(input logic [INST_W-1:0] old_w,
                                                   input logic [INST_W-1:0] new_w,
                                                   input logic [3:0]        strb);
    logic [INST_W-1:0] m;
    m = old_w;
    for (int i = 0; i < 4; i++)
      if (strb[i]) m[8*i +: 8] = new_w[8*i +: 8];
    return m;
  endfunction

endpackage

// File: rtl/iram_portb_arb_if.sv
// Port-B bundle: core and ISP request/response channels plus the RAM port-B pins.
interface iram_portb_arb_if
  import iram_portb_arb_pkg::*;
#(
  parameter int AW = 16
);
  logic              cpu_vld, cpu_rdy, cpu_we, cpu_rvld;
  logic [AW-1:0]     cpu_addr;
  logic [INST_W-1:0] cpu_wdata, cpu_rdata;
  logic [3:0]        cpu_wstrb;

  logic              isp_vld, isp_rdy, isp_we, isp_rvld;
  logic [AW-1:0]     isp_addr;
  logic [INST_W-1:0] isp_wdata, isp_rdata;

  logic              ram_enb, ram_wen;
  logic [AW-1:0]     ram_addrb;
  logic [INST_W-1:0] ram_din, ram_doutb;

  // Arbiter side
  modport slave (
    input  cpu_vld, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
    output cpu_rdy, cpu_rvld, cpu_rdata,
    input  isp_vld, isp_we, isp_addr, isp_wdata,
    output isp_rdy, isp_rvld, isp_rdata,
    output ram_enb, ram_wen, ram_addrb, ram_din,
    input  ram_doutb
  );

  // Requesters and RAM side
  modport master (
    output cpu_vld, cpu_we, cpu_addr, cpu_wdata, cpu_wstrb,
    input  cpu_rdy, cpu_rvld, cpu_rdata,
    output isp_vld, isp_we, isp_addr, isp_wdata,
    input  isp_rdy, isp_rvld, isp_rdata,
    input  ram_enb, ram_wen, ram_addrb, ram_din,
    output ram_doutb
  );
endinterface

// File: rtl/iram_portb_arb_rr_arb2.sv
// 2-way round-robin grant (bit 0 = core, bit 1 = ISP); the core wins the first tie after reset.
module iram_rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic last_isp_q;

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = last_isp_q ? 2'b01 : 2'b10;
        default: gnt = 2'b00;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)    last_isp_q <= 1'b1;
    else if (|gnt) last_isp_q <= gnt[1];

endmodule

// File: rtl/iram_portb_arb.sv
// Port-B arbiter/sequencer for the dual-port IRAM: core data bus vs ISP engine.
// Define IRAM_BYTE_WR_EN to turn partial core stores into read-modify-write sequences.
module iram_portb_arb
  import iram_portb_arb_pkg::*;
#(
  parameter int RAM_DEPTH = IRAM_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,
  iram_portb_arb_if.slave bus
);
  localparam int AW = clogb2(RAM_DEPTH-1);

  logic [1:0]        req, gnt;
  logic              idle;
  logic              enb_c, wen_c, tag_set, tag_isp;
  logic [AW-1:0]     addr_c;
  logic [INST_W-1:0] din_c;
  logic              rd_vld_q, rd_isp_q;
  logic              cpu_rvld, isp_rvld;

  assign req = {bus.isp_vld, bus.cpu_vld};

  iram_rr_arb2 u_arb (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (idle),
    .req   (req),
    .gnt   (gnt)
  );

`ifdef IRAM_BYTE_WR_EN
  rmw_st_e           state_q, state_d;
  logic              rmw_ld;
  logic [AW-1:0]     rmw_addr_q;
  logic [INST_W-1:0] rmw_wdata_q;
  logic [3:0]        rmw_strb_q;

  assign idle = (state_q == ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      rmw_addr_q  <= '0;
      rmw_wdata_q <= '0;
      rmw_strb_q  <= '0;
    end else begin
      state_q <= state_d;
      if (rmw_ld) begin
        rmw_addr_q  <= bus.cpu_addr;
        rmw_wdata_q <= bus.cpu_wdata;
        rmw_strb_q  <= bus.cpu_wstrb;
      end
    end
  end
`else
  logic unused_wstrb;
  assign unused_wstrb = ^bus.cpu_wstrb;
  assign idle = 1'b1;
`endif

  always_comb begin
    enb_c   = 1'b0;
    wen_c   = 1'b0;
    addr_c  = '0;
    din_c   = '0;
    tag_set = 1'b0;
    tag_isp = 1'b0;
`ifdef IRAM_BYTE_WR_EN
    state_d = state_q;
    rmw_ld  = 1'b0;
`endif
    if (idle) begin
      if (gnt[0]) begin
        if (!bus.cpu_we) begin
          enb_c = 1'b1; addr_c = bus.cpu_addr; tag_set = 1'b1;
`ifdef IRAM_BYTE_WR_EN
        end else if (bus.cpu_wstrb == 4'hF) begin
          wen_c = 1'b1; addr_c = bus.cpu_addr; din_c = bus.cpu_wdata;
        end else if (bus.cpu_wstrb != 4'h0) begin
          // Accept cycle only latches; old word is read next cycle, merged word written after.
          rmw_ld = 1'b1; state_d = ST_RMW_RD;
        end
`else
        end else begin
          wen_c = 1'b1; addr_c = bus.cpu_addr; din_c = bus.cpu_wdata;
        end
`endif
      end else if (gnt[1]) begin
        addr_c = bus.isp_addr;
        if (bus.isp_we) begin
          wen_c = 1'b1; din_c = bus.isp_wdata;
        end else begin
          enb_c = 1'b1; tag_set = 1'b1; tag_isp = 1'b1;
        end
      end
    end
`ifdef IRAM_BYTE_WR_EN
    else if (state_q == ST_RMW_RD) begin
      enb_c = 1'b1; addr_c = rmw_addr_q; state_d = ST_RMW_WR;
    end else begin
      wen_c   = 1'b1;
      addr_c  = rmw_addr_q;
      din_c   = byte_merge(bus.ram_doutb, rmw_wdata_q, rmw_strb_q);
      state_d = ST_IDLE;
    end
`endif
  end

  // Read-return tag: owner of the word arriving on ram_doutb next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q <= 1'b0;
      rd_isp_q <= 1'b0;
    end else begin
      rd_vld_q <= tag_set;
      rd_isp_q <= tag_isp;
    end
  end

  // Combinational outputs are forced low while reset is held so nothing half-issued reaches the RAM.
  assign bus.cpu_rdy   = gnt[0] & rst_n;
  assign bus.isp_rdy   = gnt[1] & rst_n;
  assign bus.ram_enb   = enb_c & rst_n;
  assign bus.ram_wen   = wen_c & rst_n;
  assign bus.ram_addrb = rst_n ? addr_c : '0;
  assign bus.ram_din   = rst_n ? din_c  : '0;

  assign cpu_rvld      = rd_vld_q & ~rd_isp_q;
  assign isp_rvld      = rd_vld_q &  rd_isp_q;
  assign bus.cpu_rvld  = cpu_rvld;
  assign bus.isp_rvld  = isp_rvld;
  assign bus.cpu_rdata = cpu_rvld ? bus.ram_doutb : '0;
  assign bus.isp_rdata = isp_rvld ? bus.ram_doutb : '0;

endmodule

// File: tb/tb_iram_portb_arb.sv
// Directed + randomized bench for iram_portb_arb against a cycle-level behavioural model.
module tb_iram_portb_arb;
  import iram_portb_arb_pkg::*;

  localparam int AW = 16;
`ifdef IRAM_BYTE_WR_EN
  localparam bit BYTE_WR = 1'b1;
`else
  localparam bit BYTE_WR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  iram_portb_arb_if #(.AW(AW)) bus();

  iram_portb_arb #(.RAM_DEPTH(65536)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int a);
    return 32'h5A5A_0000 ^ (32'(a) * 32'h0100_0193);
  endfunction

  function automatic logic [31:0] mrg(input logic [31:0] o, input logic [31:0] n, input logic [3:0] s);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) if (s[i]) mask = mask | (32'hFF << (8*i));
    return (n & mask) | (o & ~mask);
  endfunction

  // RAM port B model: registered read, write on wen; tb preset port for loading test words.
  logic [31:0]   ram [0:65535];
  logic          ram_init = 1'b0;
  logic          pre_we = 1'b0;
  logic [AW-1:0] pre_addr = '0;
  logic [31:0]   pre_data = '0;

  always @(posedge clk) begin
    if (!ram_init) begin
      for (int i = 0; i < 65536; i++) ram[i] <= init_val(i);
      ram_init <= 1'b1;
    end else begin
      if (bus.ram_enb) bus.ram_doutb <= ram[bus.ram_addrb];
      if (bus.ram_wen) ram[bus.ram_addrb] <= bus.ram_din;
      if (pre_we) ram[pre_addr] <= pre_data;
    end
  end

  // Reference model, evaluated mid-cycle from the request inputs and the spec's rules.
  logic [31:0]   ref_mem [0:65535];
  bit            m_init = 0;
  bit            m_last_isp = 1;
  int            m_busy = 0;
  bit            p_vld = 0, p_isp = 0;
  logic [31:0]   p_data = '0;
  logic [AW-1:0] r_addr = '0;
  logic [31:0]   r_wdata = '0;
  logic [3:0]    r_strb = '0;

  always @(negedge clk) begin
    bit gc, gi, en_x, wr_x, tg, tg_isp;
    int b;
    logic [AW-1:0] ea;
    logic [31:0] ed;
    if (!m_init) begin
      for (int i = 0; i < 65536; i++) ref_mem[i] = init_val(i);
      m_init = 1;
    end
    if (pre_we) ref_mem[pre_addr] = pre_data;
    if (!rst_n) begin
      chk("rst_ctl", 64'({bus.cpu_rdy, bus.isp_rdy, bus.ram_enb, bus.ram_wen, bus.cpu_rvld, bus.isp_rvld}), 64'(0));
      chk("rst_rdata", 64'({bus.cpu_rdata, bus.isp_rdata}), 64'(0));
      chk("rst_ram", 64'({bus.ram_addrb, bus.ram_din}), 64'(0));
      m_busy = 0; m_last_isp = 1; p_vld = 0; p_isp = 0;
    end else begin
      gc = 0; gi = 0; en_x = 0; wr_x = 0; tg = 0; tg_isp = 0; ea = '0; ed = '0;
      b = m_busy;
      if (b == 0) begin
        gc = bus.cpu_vld && (!bus.isp_vld || m_last_isp);
        gi = bus.isp_vld && !gc;
        if (gc) begin
          ea = bus.cpu_addr;
          if (!bus.cpu_we) begin en_x = 1; tg = 1; end
          else if (!BYTE_WR || bus.cpu_wstrb == 4'hF) begin wr_x = 1; ed = bus.cpu_wdata; end
          else if (bus.cpu_wstrb != 4'h0) begin
            m_busy = 2; r_addr = bus.cpu_addr; r_wdata = bus.cpu_wdata; r_strb = bus.cpu_wstrb;
          end
        end else if (gi) begin
          ea = bus.isp_addr;
          if (bus.isp_we) begin wr_x = 1; ed = bus.isp_wdata; end
          else begin en_x = 1; tg = 1; tg_isp = 1; end
        end
        if (gc || gi) m_last_isp = gi;
      end else if (b == 2) begin
        en_x = 1; ea = r_addr; m_busy = 1;
      end else begin
        wr_x = 1; ea = r_addr; ed = mrg(ref_mem[r_addr], r_wdata, r_strb); m_busy = 0;
      end
      chk("ctl", 64'({bus.cpu_rdy, bus.isp_rdy, bus.ram_enb, bus.ram_wen, bus.cpu_rvld, bus.isp_rvld}),
          64'({gc, gi, en_x, wr_x, p_vld && !p_isp, p_vld && p_isp}));
      if (en_x || wr_x) chk("addr", 64'(bus.ram_addrb), 64'(ea));
      if (wr_x) chk("din", 64'(bus.ram_din), 64'(ed));
      if (p_vld) chk(p_isp ? "isp_rdata" : "cpu_rdata", 64'(p_isp ? bus.isp_rdata : bus.cpu_rdata), 64'(p_data));
      if (wr_x) ref_mem[ea] = ed;
      p_vld = tg; p_isp = tg_isp;
      if (tg) p_data = ref_mem[ea];
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic drive_cpu(input bit v, input bit we, input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
    bus.cpu_vld = v; bus.cpu_we = we; bus.cpu_addr = a; bus.cpu_wdata = d; bus.cpu_wstrb = s;
  endtask

  task automatic drive_isp(input bit v, input bit we, input logic [AW-1:0] a, input logic [31:0] d);
    bus.isp_vld = v; bus.isp_we = we; bus.isp_addr = a; bus.isp_wdata = d;
  endtask

  task automatic idle_in();
    drive_cpu(0, 0, '0, '0, '0);
    drive_isp(0, 0, '0, '0);
  endtask

  task automatic do_reset();
    tick(); idle_in(); rst_n = 1'b0;
    tick(); tick(); rst_n = 1'b1;
  endtask

  task automatic preset(input logic [AW-1:0] a, input logic [31:0] d);
    tick(); pre_we = 1'b1; pre_addr = a; pre_data = d;
    tick(); pre_we = 1'b0;
  endtask

  initial begin
    bit cdone, idone;
    idle_in();
    rst_n = 1'b0;
    tick(); tick(); rst_n = 1'b1;
    preset(16'h0010, 32'h0000_0013);
    preset(16'h0030, 32'h1122_3344);

    // 1: lone core read
    drive_cpu(1, 0, 16'h0010, '0, '0);
    @(negedge clk); chk("t1_rdy", 64'(bus.cpu_rdy), 64'(1));
    tick(); idle_in();
    @(negedge clk);
    chk("t1_rvld", 64'({bus.cpu_rvld, bus.isp_rvld}), 64'(2'b10));
    chk("t1_rdata", 64'(bus.cpu_rdata), 64'(32'h0000_0013));

    // 2: both requesting from reset -> CPU, ISP, CPU, ISP
    do_reset();
    drive_cpu(1, 0, 16'h0040, '0, '0);
    drive_isp(1, 0, 16'h0041, '0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("t2_gnt", 64'({bus.cpu_rdy, bus.isp_rdy}), 64'((i % 2 == 0) ? 2'b10 : 2'b01));
      tick();
    end
    idle_in();
    @(negedge clk); chk("t2_last_rvld", 64'({bus.cpu_rvld, bus.isp_rvld}), 64'(2'b01));

    // 3: ISP write then read-back
    tick();
    drive_isp(1, 1, 16'h0020, 32'hDEAD_BEEF);
    @(negedge clk); chk("t3_wen", 64'({bus.ram_enb, bus.ram_wen, bus.ram_addrb}), 64'({1'b0, 1'b1, 16'h0020}));
    tick(); drive_isp(1, 0, 16'h0020, '0);
    @(negedge clk); chk("t3_enb", 64'({bus.isp_rdy, bus.ram_enb, bus.ram_wen}), 64'(3'b110));
    tick(); idle_in();
    @(negedge clk);
    chk("t3_rvld", 64'(bus.isp_rvld), 64'(1));
    chk("t3_rdata", 64'(bus.isp_rdata), 64'(32'hDEAD_BEEF));

    // 4: partial core store to 0x30, followed by a read of the same word
    tick();
    drive_cpu(1, 1, 16'h0030, 32'hAABB_CCDD, 4'b0101);
    @(negedge clk); chk("t4_acc", 64'(bus.cpu_rdy), 64'(1));
    tick(); drive_cpu(1, 0, 16'h0030, '0, '0);
    for (int i = 0; i < (BYTE_WR ? 2 : 0); i++) begin
      @(negedge clk); chk("t4_hold", 64'({bus.cpu_rdy, bus.isp_rdy}), 64'(0));
      tick();
    end
    @(negedge clk); chk("t4_rd_acc", 64'(bus.cpu_rdy), 64'(1));
    tick(); idle_in();
    @(negedge clk); chk("t4_word", 64'(bus.cpu_rdata), 64'(BYTE_WR ? 32'h11BB_33DD : 32'hAABB_CCDD));

    // 5: reset in the cycle after acceptance (RMW_RD with byte writes, pending read otherwise)
    preset(16'h0030, 32'h1122_3344);
    drive_cpu(1, BYTE_WR, 16'h0030, 32'h0, 4'b0011);
    @(negedge clk); chk("t5_acc", 64'(bus.cpu_rdy), 64'(1));
    tick(); idle_in(); rst_n = 1'b0;
    @(negedge clk);
    chk("t5_zero", 64'({bus.cpu_rdy, bus.isp_rdy, bus.ram_enb, bus.ram_wen, bus.cpu_rvld, bus.isp_rvld}), 64'(0));
    tick(); tick(); rst_n = 1'b1;
    drive_cpu(1, 0, 16'h0030, '0, '0);
    @(negedge clk); chk("t5_rd_acc", 64'(bus.cpu_rdy), 64'(1));
    tick(); idle_in();
    @(negedge clk); chk("t5_word", 64'(bus.cpu_rdata), 64'(32'h1122_3344));

    // 6: quiet bus
    tick();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); chk("t6_quiet", 64'({bus.ram_enb, bus.ram_wen, bus.cpu_rvld, bus.isp_rvld}), 64'(0));
      tick();
    end

    // Random traffic; requests are held until accepted, occasional resets
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      cdone = !bus.cpu_vld || bus.cpu_rdy;
      idone = !bus.isp_vld || bus.isp_rdy;
      tick();
      if (cdone) begin
        if ($urandom_range(0, 3) != 0)
          drive_cpu(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom,
                    ($urandom_range(0, 1) != 0) ? 4'hF : 4'($urandom));
        else
          drive_cpu(0, 0, '0, '0, '0);
      end
      if (idone) begin
        if ($urandom_range(0, 2) != 0)
          drive_isp(1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), $urandom);
        else
          drive_isp(0, 0, '0, '0);
      end
      if ($urandom_range(0, 599) == 0) begin
        rst_n = 1'b0; tick(); rst_n = 1'b1;
      end
    end

    idle_in();
    tick(); tick(); tick();
    for (int a = 0; a < 64; a++) chk("mem", 64'(ram[a]), 64'(ref_mem[a]));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
